serial_magnitude_comparator_ctrl: RTL
=====================================

// Module: serial_magnitude_comparator_ctrl
// PURPOSE
//  Bit-serial N-bit magnitude comparator that reuses one 1-bit comparator cell for every bit.
//  - On start, latches two WIDTH-bit operands and walks them MSB-first, one bit per clock.
//  - Stops at the first differing bit, or after the LSB if the operands are equal.
//  - Reports equal/greater/less with a start/busy/done handshake.
//  - Sits between a requesting datapath and the shared 1-bit compare cell, as the cell's sequencer.
// PARAMETERS
//  WIDTH       8   operand width in bits, >= 2
//  EARLY_EXIT  1   1: stop at the first differing bit; 0: always scan all WIDTH bits
// PORTS
//  clk           in   1                     rising-edge clock
//  rst_n         in   1                     async active-low reset
//  start         in   1                     request a comparison; sampled only when not busy
//  a             in   WIDTH                 operand A, captured on the accepted start
//  b             in   WIDTH                 operand B, captured on the accepted start
//  busy          out  1                     comparison in progress
//  done          out  1                     one-cycle pulse: result now valid
//  a_equals_b    out  1                     result: A == B
//  a_greater_b   out  1                     result: A > B (unsigned)
//  a_less_b      out  1                     result: A < B (unsigned)
//  cycles_used   out  $clog2(WIDTH+1)       number of bit-compare cycles taken
// BEHAVIOUR
//  Reset
//   - rst_n low: state=IDLE, all outputs 0, operand registers and bit index cleared.
//   - Effect is immediate (async); rst_n is sampled synchronously for release.
//   - Reset mid-operation aborts the comparison; no done pulse is produced.
//  FSM states: IDLE, COMPARE, DONE
//  IDLE
//   - busy=0.
//   - On start=1 at edge T: latch a, b; idx=WIDTH-1; cnt=0.
//   - Also at edge T: clear all three result flags and cycles_used; go to COMPARE.
//  COMPARE
//   - busy=1.
//   - Each edge compares sa[idx] vs sb[idx] through the 1-bit compare cell; cnt increments by 1.
//   - EARLY_EXIT=1, bits differ: set gt or lt from that bit; go to DONE.
//   - EARLY_EXIT=0: the first differing bit is recorded; later bits are ignored.
//   - idx==0 with no difference seen: set eq=1; go to DONE.
//   - Otherwise: idx decrements by 1.
//  DONE
//   - Lasts exactly one cycle: busy=0, done=1, cycles_used=cnt.
//   - Next edge returns to IDLE.
//   - start=1 sampled in DONE is accepted exactly as in IDLE: back-to-back comparisons, no idle gap.
//  Latency
//   - Start accepted at edge T; done is high during the cycle after edge T+k.
//   - k = index of the first differing bit counted from the MSB (1..WIDTH), or WIDTH if equal.
//   - EARLY_EXIT=0: k = WIDTH always.
//  Start while busy
//   - start=1 during COMPARE is ignored. It is not queued.
//   - Operand inputs a, b are don't-care while busy.
//  Results
//   - Hold their values after done until the next start is accepted.
//   - Exactly one of eq/gt/lt is 1 whenever a result is valid.
//   - All three flags are 0 while busy and after reset.
//  Arithmetic
//   - Comparison is unsigned.
//   - cnt saturates at WIDTH. It cannot exceed WIDTH by construction; the saturation is defensive only.
// TESTING (WIDTH=8)
//  1 a=8'hA5,b=8'hA5,start -> busy 8 cycles; done pulse; eq=1, gt=0, lt=0, cycles_used=8
//  2 a=8'h80,b=8'h7F,start -> done 1 cycle after COMPARE entry; gt=1, cycles_used=1
//  3 a=8'h12,b=8'h13,start -> lt=1, cycles_used=8; with EARLY_EXIT=0, a=8'h80,b=8'h00 -> gt=1, cycles_used=8
//  4 start held high through COMPARE -> ignored; start high in the DONE cycle -> new compare, busy next cycle
//  5 rst_n low at 3rd COMPARE cycle -> all outputs 0 at once, no done pulse; next start behaves normally
//  6 result hold: after test 2, idle 5 cycles with a/b toggling -> gt stays 1 until next accepted start

Source files
------------

// File: rtl/serial_magnitude_comparator_ctrl.sv
// Bit-serial unsigned magnitude comparator: walks two latched operands MSB-first
// through a single 1-bit compare cell and reports eq/gt/lt with a start/busy/done handshake.
module serial_magnitude_comparator_ctrl #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       busy,
  output logic                       done,
  output logic                       a_equals_b,
  output logic                       a_greater_b,
  output logic                       a_less_b,
  output logic [$clog2(WIDTH+1)-1:0] cycles_used
);

  localparam int CW = $clog2(WIDTH+1);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t         state;
  state_t         next_state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_next;
  logic           seen;
  logic           pend_gt;
  logic           pend_lt;
  logic           cell_gt;
  logic           cell_lt;
  logic           differ;
  logic           finish;
  logic           accept;
  logic           res_gt;
  logic           res_lt;

  // The shared 1-bit compare cell, steered by the current bit index.
  always_comb begin
    cell_gt = sa[idx] & ~sb[idx];
    cell_lt = ~sa[idx] & sb[idx];
    differ  = cell_gt | cell_lt;
  end

  always_comb begin
    accept   = start && (state == IDLE || state == DONE);
    finish   = ((EARLY_EXIT != 0) && differ) || (idx == '0);
    cnt_next = (cnt == CW'(WIDTH)) ? cnt : cnt + CW'(1);
    res_gt   = seen ? pend_gt : cell_gt;
    res_lt   = seen ? pend_lt : cell_lt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = COMPARE;
      COMPARE: if (finish) next_state = DONE;
      DONE:    next_state = start ? COMPARE : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == COMPARE);
    done = (state == DONE);
  end

  // Operand, index and result registers; results hold until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa          <= '0;
      sb          <= '0;
      idx         <= '0;
      cnt         <= '0;
      seen        <= 1'b0;
      pend_gt     <= 1'b0;
      pend_lt     <= 1'b0;
      a_equals_b  <= 1'b0;
      a_greater_b <= 1'b0;
      a_less_b    <= 1'b0;
      cycles_used <= '0;
    end else if (accept) begin
      sa          <= a;
      sb          <= b;
      idx         <= IW'(WIDTH-1);
      cnt         <= '0;
      seen        <= 1'b0;
      pend_gt     <= 1'b0;
      pend_lt     <= 1'b0;
      a_equals_b  <= 1'b0;
      a_greater_b <= 1'b0;
      a_less_b    <= 1'b0;
      cycles_used <= '0;
    end else if (state == COMPARE) begin
      cnt <= cnt_next;
      if (finish) begin
        cycles_used <= cnt_next;
        a_greater_b <= res_gt;
        a_less_b    <= res_lt;
        a_equals_b  <= ~(res_gt | res_lt);
      end else begin
        idx <= idx - IW'(1);
        // Without early exit only the most significant difference decides.
        if (!seen && differ) begin
          seen    <= 1'b1;
          pend_gt <= cell_gt;
          pend_lt <= cell_lt;
        end
      end
    end
  end

endmodule
